// File: rtl/display_timing.sv
// Parametrised raster timing generator with aligned sync/blank delay line, test-pattern
// source and registered colour gate, sitting between the frame renderer and the VGA pins.
module display_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int PIPE_DEPTH = 5,
  parameter int COLOR_BITS = 4,
  parameter int CW         = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [1:0]              test_mode,
  input  logic [3*COLOR_BITS-1:0] pix_color,
  output logic [CW-1:0]           x,
  output logic [CW-1:0]           y,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame_start,
  output logic                    line_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int CB       = COLOR_BITS;
  localparam int CLRW     = 3 * COLOR_BITS;

  typedef struct packed {
    logic            active;
    logic            hs;
    logic            vs;
    logic            fs;
    logic            ls;
    logic [1:0]      mode;
    logic [CLRW-1:0] tcol;
  } stage_t;

  function automatic stage_t idle_stage();
    stage_t s;
    s    = '0;
    s.hs = ~HSYNC_POL;
    s.vs = ~VSYNC_POL;
    return s;
  endfunction

  logic [CW-1:0]   x_q, x_d;
  logic [CW-1:0]   y_q, y_d;
  logic [1:0]      mode_q, mode_d;
  stage_t          pipe_q [PIPE_DEPTH];
  stage_t          pipe_d [PIPE_DEPTH];
  stage_t          raw;
  stage_t          last;
  logic [CLRW-1:0] col_q, col_d;
  logic            de_q, de_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            fs_q, fs_d;
  logic            ls_q, ls_d;
  logic            origin;
  logic [2:0]      bar_idx;
  int              xi;
  int              yi;

  // Raster counters; a low enable parks the raster at the frame origin.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (!enable) begin
      x_d = '0;
      y_d = '0;
    end else if (x_q == CW'(H_TOTAL - 1)) begin
      x_d = '0;
      if (y_q == CW'(V_TOTAL - 1)) y_d = '0;
      else                         y_d = y_q + CW'(1);
    end else begin
      x_d = x_q + CW'(1);
    end
  end

  // mode_d is the mode in force for this raster position: at the origin it is the
  // freshly latched value, so the whole new frame (including pixel 0,0) uses it.
  always_comb begin
    origin = (x_q == '0) && (y_q == '0);
    mode_d = (enable && origin) ? test_mode : mode_q;
  end

  always_comb begin
    xi      = int'(x_q);
    yi      = int'(y_q);
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (xi * 8 >= k * H_ACTIVE) bar_idx = 3'(k);
    end

    raw        = idle_stage();
    raw.active = enable && (xi < H_ACTIVE) && (yi < V_ACTIVE);
    raw.hs     = (enable && xi >= HS_START && xi < HS_END) ? HSYNC_POL : ~HSYNC_POL;
    raw.vs     = (enable && yi >= VS_START && yi < VS_END) ? VSYNC_POL : ~VSYNC_POL;
    raw.fs     = enable && origin;
    raw.ls     = enable && (x_q == '0);
    raw.mode   = mode_d;
    case (mode_d)
      2'd1:    raw.tcol = '1;
      2'd2:    raw.tcol = {{CB{bar_idx[2]}}, {CB{bar_idx[1]}}, {CB{bar_idx[0]}}};
      2'd3:    raw.tcol = (x_q[4:0] == 5'd0 || y_q[4:0] == 5'd0) ? '1 : '0;
      default: raw.tcol = '0;
    endcase
  end

  // Delay line matching the renderer latency from x/y to pix_color.
  always_comb begin
    pipe_d[0] = raw;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_comb begin
    last  = pipe_q[PIPE_DEPTH-1];
    col_d = '0;
    if (last.active) col_d = (last.mode == 2'd0) ? pix_color : last.tcol;
    de_d = last.active;
    hs_d = last.hs;
    vs_d = last.vs;
    fs_d = last.fs;
    ls_d = last.ls;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= 2'd0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_q[i] <= idle_stage();
      end
      col_q  <= '0;
      de_q   <= 1'b0;
      hs_q   <= ~HSYNC_POL;
      vs_q   <= ~VSYNC_POL;
      fs_q   <= 1'b0;
      ls_q   <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      mode_q <= mode_d;
      pipe_q <= pipe_d;
      col_q  <= col_d;
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fs_q   <= fs_d;
      ls_q   <= ls_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign red         = col_q[CLRW-1 -: CB];
  assign green       = col_q[2*CB-1 -: CB];
  assign blue        = col_q[CB-1:0];
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule

// File: tb/tb_display_timing.sv
// Directed bench for display_timing: full 800-clock lines with a short vertical raster,
// plus a tiny-geometry instance for sync placement and polarity.
module tb_display_timing;

  localparam int HT    = 800;
  localparam int VT    = 17;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst, rst_s;
  logic        enable, enable_s;
  logic [1:0]  test_mode, test_mode_s;
  logic [11:0] pix_color, pix_color_s;
  logic [10:0] x, y, x_s, y_s;
  logic [3:0]  red, green, blue, red_s, green_s, blue_s;
  logic        hsync, vsync, de, frame_start, line_start;
  logic        hsync_s, vsync_s, de_s, frame_start_s, line_start_s;
  logic [11:0] rend_q [5];

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  display_timing #(
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .test_mode(test_mode), .pix_color(pix_color),
    .x(x), .y(y), .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
    .de(de), .frame_start(frame_start), .line_start(line_start)
  );

  display_timing #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .PIPE_DEPTH(2)
  ) dut_s (
    .clk(clk), .rst(rst_s), .enable(enable_s), .test_mode(test_mode_s), .pix_color(pix_color_s),
    .x(x_s), .y(y_s), .red(red_s), .green(green_s), .blue(blue_s), .hsync(hsync_s),
    .vsync(vsync_s), .de(de_s), .frame_start(frame_start_s), .line_start(line_start_s)
  );

  // Renderer stand-in: 5-clock latency copy of {x[3:0], y[3:0], 4'h5}.
  always @(posedge clk) begin
    rend_q[0] <= {x[3:0], y[3:0], 4'h5};
    for (int i = 1; i < 5; i++) rend_q[i] <= rend_q[i-1];
  end
  assign pix_color = rend_q[4];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_fs(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < limit);
  endtask

  task automatic check_reset_main(input string tag);
    check_eq(tag, {x, y, red, green, blue, de, hsync, vsync, frame_start, line_start},
             {11'd0, 11'd0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    int n, e_hs, e_vs, e_de, e_col, e_ls, e_fs, ls_cnt;
    int de_total, de_line0, hs_fall, hs_low0, vs_fall, vs_low, ls_bad, fs_bad, pix_err;
    int grid0_err, grid1_err, xx, xs, ys;
    logic [2:0] kb;
    logic exp_hs, exp_vs, exp_de;

    rst = 1'b0; rst_s = 1'b0;
    enable = 1'b1; enable_s = 1'b1;
    test_mode = 2'd0; test_mode_s = 2'd0;
    pix_color_s = 12'hABC;
    repeat (3) tick();
    check_reset_main("reset_main");
    check_eq("reset_small", {x_s, y_s, red_s, green_s, blue_s, de_s, hsync_s, vsync_s,
             frame_start_s, line_start_s}, {11'd0, 11'd0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    // Small geometry: 12 x 7 raster, latency 3, active-high hsync.
    rst_s = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start_s && n < 20);
    check_eq("s_fs_latency", n, 3);
    e_hs = 0; e_vs = 0; e_de = 0; e_col = 0; e_ls = 0; e_fs = 0; ls_cnt = 0;
    for (int t = 0; t < 84; t++) begin
      xs = t % 12;
      ys = t / 12;
      exp_hs = (xs >= 9 && xs <= 10);
      exp_vs = (ys != 5);
      exp_de = (xs < 8 && ys < 4);
      if (hsync_s !== exp_hs) e_hs++;
      if (vsync_s !== exp_vs) e_vs++;
      if (de_s !== exp_de) e_de++;
      if ({red_s, green_s, blue_s} !== (exp_de ? 12'hABC : 12'h000)) e_col++;
      if (line_start_s !== (xs == 0)) e_ls++;
      if (line_start_s === 1'b1) ls_cnt++;
      if (frame_start_s !== (t == 0)) e_fs++;
      tick();
    end
    check_eq("s_frame_84", frame_start_s, 1'b1);
    check_eq("s_hsync_place", e_hs, 0);
    check_eq("s_vsync_place", e_vs, 0);
    check_eq("s_de_place", e_de, 0);
    check_eq("s_colour", e_col, 0);
    check_eq("s_line_start_place", e_ls, 0);
    check_eq("s_line_start_count", ls_cnt, 7);
    check_eq("s_frame_start_once", e_fs, 0);

    // Main instance: release reset, first frame_start 6 clocks after the origin cycle.
    check_reset_main("reset_main_held");
    rst = 1'b1;
    wait_fs(40, n);
    check_eq("fs_latency", n, 6);
    check_eq("raster_lead", {x, y}, {11'd6, 11'd0});

    // Frame 1: pass-through timing and pixel content.
    de_total = 0; de_line0 = 0; hs_fall = -1; hs_low0 = 0; vs_fall = -1; vs_low = 0;
    ls_cnt = 0; ls_bad = 0; fs_bad = 0; pix_err = 0;
    for (int t = 0; t < FRAME; t++) begin
      if (de) de_total++;
      if (de && t < HT) de_line0++;
      if (!hsync && hs_fall < 0) hs_fall = t;
      if (!hsync && t < HT) hs_low0++;
      if (!vsync && vs_fall < 0) vs_fall = t;
      if (!vsync) vs_low++;
      if (line_start) begin
        ls_cnt++;
        if (t % HT != 0) ls_bad++;
      end
      if (frame_start && t != 0) fs_bad++;
      if (t < 640 && {red, green, blue} !== {t[3:0], 4'h0, 4'h5}) pix_err++;
      if (t == 1)        check_eq("pix_1", {red, green, blue}, 12'h105);
      if (t == 15)       check_eq("pix_15", {red, green, blue}, 12'hF05);
      if (t == 639)      check_eq("pix_639", {red, green, blue, de}, {12'hF05, 1'b1});
      if (t == 640)      check_eq("pix_640_blank", {red, green, blue, de}, {12'h000, 1'b0});
      if (t == 5*HT + 3) check_eq("pix_3_5", {red, green, blue}, 12'h355);
      tick();
    end
    check_eq("frame_period", frame_start, 1'b1);
    check_eq("de_line0", de_line0, 640);
    check_eq("de_total", de_total, 640 * 12);
    check_eq("hsync_fall", hs_fall, 656);
    check_eq("hsync_width", hs_low0, 96);
    check_eq("vsync_fall", vs_fall, 13 * HT);
    check_eq("vsync_width", vs_low, 2 * HT);
    check_eq("line_start_count", ls_cnt, VT);
    check_eq("line_start_place", ls_bad, 0);
    check_eq("frame_start_once", fs_bad, 0);
    check_eq("line0_pixels", pix_err, 0);

    // Frame 2: mode 2 requested mid-frame must not show until the next frame.
    for (int t = 0; t < FRAME; t++) begin
      if (t == 6*HT)         test_mode = 2'd2;
      if (t == 8*HT + 40)    check_eq("midframe_pass_40", {red, green, blue}, 12'h885);
      if (t == 8*HT + 360)   check_eq("midframe_pass_360", {red, green, blue}, 12'h885);
      tick();
    end
    check_eq("frame2_period", frame_start, 1'b1);

    // Frame 3: colour bars, 80 pixels each.
    for (int t = 0; t < FRAME; t++) begin
      if (t < 640 && t % 80 == 40) begin
        kb = 3'(t / 80);
        check_eq($sformatf("bar_%0d", t / 80), {red, green, blue},
                 {{4{kb[2]}}, {4{kb[1]}}, {4{kb[0]}}});
      end
      if (t == 79)   check_eq("bar_edge_79", {red, green, blue}, 12'h000);
      if (t == 80)   check_eq("bar_edge_80", {red, green, blue}, 12'h00F);
      if (t == 639)  check_eq("bar_edge_639", {red, green, blue}, 12'hFFF);
      if (t == 5*HT) test_mode = 2'd3;
      tick();
    end
    check_eq("frame3_period", frame_start, 1'b1);

    // Frame 4: grid, then drop enable mid-line.
    grid0_err = 0; grid1_err = 0;
    for (int t = 0; t < 3000; t++) begin
      if (t < 640 && {red, green, blue} !== 12'hFFF) grid0_err++;
      if (t >= HT && t < HT + 640) begin
        xx = t - HT;
        if ({red, green, blue} !== ((xx % 32 == 0) ? 12'hFFF : 12'h000)) grid1_err++;
        if (xx == 0)  check_eq("grid_l1_x0", {red, green, blue}, 12'hFFF);
        if (xx == 1)  check_eq("grid_l1_x1", {red, green, blue}, 12'h000);
        if (xx == 32) check_eq("grid_l1_x32", {red, green, blue}, 12'hFFF);
        if (xx == 64) check_eq("grid_l1_x64", {red, green, blue}, 12'hFFF);
      end
      if (t == 1) check_eq("grid_l0_x1", {red, green, blue}, 12'hFFF);
      tick();
    end
    check_eq("grid_line0", grid0_err, 0);
    check_eq("grid_line1", grid1_err, 0);

    enable = 1'b0;
    repeat (6) tick();
    check_eq("disable_drain", {red, green, blue, de, hsync, vsync},
             {12'h000, 1'b0, 1'b1, 1'b1});
    check_eq("disable_raster", {x, y}, {11'd0, 11'd0});
    e_de = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (de || frame_start || line_start || !hsync || !vsync) e_de++;
    end
    check_eq("disable_quiet", e_de, 0);
    enable = 1'b1;
    tick();
    check_eq("reenable_x", x, 11'd1);
    wait_fs(40, n);
    check_eq("reenable_fs_latency", n + 1, 6);

    // Mid-frame reset behaves like power-up.
    repeat (500) tick();
    rst = 1'b0;
    #1;
    check_reset_main("reset_async");
    repeat (2) tick();
    check_reset_main("reset_mid_held");
    rst = 1'b1;
    wait_fs(40, n);
    check_eq("reset_mid_fs_latency", n, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display_timing.md
Name: display_timing

Overview:
- Parametrised successor to the fixed 640x480 display output stage. Combines the raster timing generator, the sync/blank alignment delay line and the output colour gate in one block.
- Adds configurable timing, sync polarity, colour depth and renderer latency, plus a built-in test-pattern generator, a global enable, and frame/line strobes.
- Sits between the frame renderer (which consumes x/y and returns a colour) and the VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HSYNC_POL, 0, active level of hsync
- VSYNC_POL, 0, active level of vsync
- PIPE_DEPTH, 5, renderer latency in clocks from x/y to pix_color (legal range 1..16)
- COLOR_BITS, 4, bits per colour channel
- CW, 11, coordinate width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  raster running when high
- test_mode  in  2  0 pass-through, 1 solid white, 2 colour bars, 3 grid
- pix_color  in  3*COLOR_BITS  renderer colour {r,g,b} for the x/y presented PIPE_DEPTH clocks earlier
- x  out  CW  current horizontal counter
- y  out  CW  current vertical counter
- red, green, blue  out  COLOR_BITS each  registered pixel colour
- hsync, vsync  out  1  registered syncs
- de  out  1  registered data-enable (active video)
- frame_start  out  1  one-clock pulse aligned with the output pixel (0,0)
- line_start  out  1  one-clock pulse aligned with output pixel x=0 of every line, including blanked lines

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP.
  - V_TOTAL likewise from the vertical parameters.
- Counters:
  - x counts 0..H_TOTAL-1 and wraps to 0.
  - y increments on the x wrap and wraps to 0 after V_TOTAL-1.
  - x and y are registers.
- Raw (stage-0) signals, combinational from x/y:
  - active = (x < H_ACTIVE) && (y < V_ACTIVE).
  - hs_raw = HSYNC_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL.
  - vs_raw is the same construction on y with the vertical parameters and VSYNC_POL.
  - fs_raw = (x==0 && y==0); ls_raw = (x==0).
- Test-pattern colour at stage 0 uses the latched mode:
  - Mode 1: all ones.
  - Mode 2: bar index = x*8/H_ACTIVE (0..7), giving colour {idx[2],idx[1],idx[0]}, each bit replicated to COLOR_BITS. Implement with a comparator chain, not a divider.
  - Mode 3: white when x[4:0]==0 or y[4:0]==0, else black.
- Delay line: sync, active, strobes, the test colour and the latched mode pass through a PIPE_DEPTH-stage shift register.
- Output register after the delay line:
  - Colour = 0 if delayed active is 0.
  - Otherwise pix_color in mode 0, or the delayed test colour in modes 1–3.
- Total latency from x/y to pins is PIPE_DEPTH+1 clocks, for all outputs.
- test_mode is latched only when x==0 && y==0 (raster at frame origin). A mid-frame change takes effect on the next frame, so there is no tearing.
- enable low:
  - x and y are synchronously cleared to 0 and held.
  - Stage-0 signals are forced to inactive: active=0, syncs at inactive level, strobes 0.
  - After the delay line drains, outputs are black, de=0 and syncs are inactive.
  - On enable rising, counting starts from (0,0); the first frame_start appears PIPE_DEPTH+1 clocks later.
- Reset (rst=0, asynchronous):
  - x=y=0, red/green/blue=0, de=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL, frame_start=line_start=0.
  - All delay stages are loaded with the inactive values; latched mode=0.
- Reset release mid-frame: identical to power-up. There is no partial-frame output.
- Simultaneous events: at (H_TOTAL-1, V_TOTAL-1) both counters wrap in the same clock. A test_mode latch and an enable fall in the same clock: enable wins (no latch occurs).

Test Plan:
- Reset with defaults, hold 3 clocks, release with enable=1 → required response:
  - All outputs at reset values during reset.
  - frame_start first high exactly 6 clocks after the x=0,y=0 cycle; the next one 420000 clocks later.
- Defaults, mode 0, pix_color fed as a 5-clock delayed copy of {x[3:0],y[3:0],4'h5} → required response:
  - Output pixel n of line 0 shows red=n[3:0], green=0, blue=5.
  - de high for exactly 640 clocks per visible line.
  - hsync low for 96 clocks starting 656 clocks after de rises.
- Small parameters (H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, HSYNC_POL=1, PIPE_DEPTH=2) → required response:
  - Frame is 84 clocks.
  - hsync high on x=9..10, delayed by 3 clocks.
  - vsync low during y=5, delayed by 3 clocks.
  - line_start every 12 clocks.
- Switch test_mode 0→2 at y=100 → required response:
  - Remainder of the frame is pass-through.
  - Next frame shows bars: 8 × 80-pixel bars, first black, last white, bar 4 = red only.
- Drop enable mid-line for 20 clocks, then raise → required response:
  - Within 6 clocks, colour=0, de=0, syncs inactive.
  - After re-enable, x restarts at 0 and frame_start fires 6 clocks later.
- Mode 3 with defaults → required response: white at x=0,32,64…, black at x=1, line 0 entirely white, line 1 white only at grid columns.
